uart_rx_core: RTL
=================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 347, clk cycles per bit; legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port rxd, input, 1, asynchronous serial line; idle high.
REQ-007 Port parity_mode, input, 2, 00 none, 01 even, 10 odd, 11 treated as none; sampled only at start-bit confirmation.
REQ-008 Port rx_data, output, DATA_BITS, received word, LSB first on the line.
REQ-009 Port rx_valid, output, 1, rx_data and error flags hold a valid frame.
REQ-010 Port rx_ready, input, 1, consumer accepts the frame when rx_valid and rx_ready are both high in one cycle.
REQ-011 Port frame_err, output, 1, a sampled stop bit was low; qualified by rx_valid.
REQ-012 Port parity_err, output, 1, parity mismatch; qualified by rx_valid.
REQ-013 Port overrun, output, 1, sticky: a frame completed while the previous one was still unaccepted.
REQ-014 Port busy, output, 1, FSM not in IDLE.

Function
REQ-015 rxd SHALL pass through a 2-flop synchroniser; all FSM decisions use the synchronised value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-017 IDLE: a synchronised high-to-low transition -> START; the bit counter clears to 0.
REQ-018 Each bit SHALL be the 2-of-3 majority of samples taken at counter values CLKS_PER_BIT/2-1, /2 and /2+1 (integer division).
REQ-019 START: a majority result of 1 means a glitch and SHALL return to IDLE with no output; a result of 0 -> DATA when the counter reaches CLKS_PER_BIT-1.
REQ-020 DATA: shift DATA_BITS bits LSB-first, then -> PARITY if parity is enabled, else -> STOP.
REQ-021 PARITY: compute parity as the XOR of the data bits and the received parity bit; even mode errors when the result is 1, odd mode errors when it is 0.
REQ-022 STOP: check STOP_BITS bits; any low majority sets frame_err. Leave STOP at the mid-sample of the last stop bit, not at the bit end, so a back-to-back start bit is caught.
REQ-023 DONE (one cycle): load the output register, assert rx_valid, -> IDLE.
REQ-024 rx_valid SHALL stay high until the handshake; the handshake cycle clears it unless DONE loads a new frame in the same cycle, in which case rx_valid stays high with the new data.
REQ-025 DONE while rx_valid && !rx_ready: overwrite with the new frame and set overrun; overrun clears only on reset.
REQ-026 Latency SHALL be the rx_valid rise exactly 1 cycle after the last stop-bit mid-sample, plus 2 cycles of synchroniser delay relative to the line.
REQ-027 A frame with frame_err SHALL still be delivered, with its flags.

Reset
REQ-028 rst high SHALL, at the next edge, force IDLE, counters 0, synchroniser 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-029 Reset mid-frame SHALL discard the frame with no rx_valid pulse.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, parity_mode and the PARITY state SHALL behave as specified above.
REQ-031 Without UART_RX_PARITY_EN, the port parity_mode SHALL remain but be ignored, the PARITY state SHALL be absent, and parity_err SHALL be tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the parity_mode encodings and the majority-of-3 function.
REQ-033 Sub-module uart_bit_timer SHALL hold the per-bit counter, with clear and enable inputs and three sample-strobe outputs.

Verification
REQ-034 With CLKS_PER_BIT=16, DATA_BITS=8, no parity, the frame 0xA5 with rx_ready=1 SHALL produce rx_data=0xA5, a 1-cycle rx_valid, and no errors.
REQ-035 With even parity, 0x07 sent with a wrong parity bit of 0 SHALL produce rx_data=0x07 and parity_err=1; the same byte with parity 1 SHALL produce parity_err=0.
REQ-036 A low pulse of 4 clk on idle rxd (CLKS_PER_BIT=16) SHALL produce no rx_valid and return busy to 0.
REQ-037 Byte 0x3C with the stop bit forced low SHALL produce rx_valid with frame_err=1 and rx_data=0x3C.
REQ-038 Two back-to-back frames 0x11 and 0x22 with rx_ready=0 SHALL leave rx_data=0x22 and overrun=1.
REQ-039 rst asserted during bit 4 of a frame SHALL produce no rx_valid; a following frame 0x5A SHALL be received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM states, parity-mode codes, majority vote.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } rx_state_e;
`endif

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter with mid-bit sample strobes (half-1, half, half+1) and a bit-end strobe.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic samp_a,
  output logic samp_b,
  output logic samp_c,
  output logic bit_end
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign samp_a  = (cnt_q == CW'(HALF - 1));
  assign samp_b  = (cnt_q == CW'(HALF));
  assign samp_c  = (cnt_q == CW'(HALF + 1));

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses <= only, so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, majority-of-3 bit sampling, registered output with overrun.
// Define UART_RX_PARITY_EN to enable the parity bit; otherwise parity_mode is ignored.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rxd_prev_q;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 perr_w;

  logic rxd_s, start_edge, maj;
  logic samp_a, samp_b, samp_c, bit_end;

  assign rxd_s      = sync_q[1];
  assign start_edge = rxd_prev_q & ~rxd_s;
  assign maj        = maj3(samp_q[0], samp_q[1], rxd_s);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == ST_IDLE) && !start_edge),
    .en      (1'b1),
    .samp_a  (samp_a),
    .samp_b  (samp_b),
    .samp_c  (samp_c),
    .bit_end (bit_end)
  );

`ifdef UART_RX_PARITY_EN
  parity_mode_e pmode_q, pmode_d;
  logic         perr_q, perr_d, parity_on;
  logic         parity_err_q, parity_err_d;

  assign parity_on = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign perr_w    = perr_q;
  assign parity_err = parity_err_q;

  always_comb begin
    pmode_d      = pmode_q;
    perr_d       = perr_q;
    parity_err_d = parity_err_q;
    if (state_q == ST_IDLE && start_edge) perr_d = 1'b0;
    if (state_q == ST_START && bit_end)   pmode_d = parity_mode_e'(parity_mode);
    if (state_q == ST_PARITY && samp_c)
      perr_d = (pmode_q == PAR_EVEN) ? (^shift_q ^ maj) : ~(^shift_q ^ maj);
    if (state_q == ST_DONE) parity_err_d = perr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pmode_q      <= PAR_NONE;
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      pmode_q      <= pmode_d;
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
    end
  end
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign perr_w     = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    sync_d    = {sync_q[0], rxd};
    samp_d    = samp_q;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ferr_d    = ferr_q;
    if (samp_a) samp_d[0] = rxd_s;
    if (samp_b) samp_d[1] = rxd_s;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          ferr_d    = 1'b0;
        end
      end
      ST_START: begin
        if (samp_c && maj) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (samp_c) begin
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (bit_end && bit_cnt_q == 4'(DATA_BITS)) begin
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d   = parity_on ? ST_PARITY : ST_STOP;
`else
          state_d   = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leave at the last stop-bit decision so a following start edge is seen from IDLE.
        if (samp_c) begin
          if (!maj) ferr_d = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (state_q == ST_DONE) begin
      rx_data_d   = shift_q;
      frame_err_d = ferr_q;
      rx_valid_d  = 1'b1;
      if (rx_valid_q && !rx_ready) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      rxd_prev_q  <= 1'b1;
      samp_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ferr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rxd_prev_q  <= rxd_s;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ferr_q      <= ferr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

  logic unused_perr;
  assign unused_perr = perr_w;

endmodule
